pipe_adder: RTL



---
 rtl/pipe_adder_pkg.sv | 17 +
 rtl/adder_seg.sv | 42 ++++
 rtl/pipe_adder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg -- shared helpers for the segmented pipelined adder.
//
// Contents:
//   num_seg(width, seg_w) : number of pipeline stages for a WIDTH-bit adder
//                           split into SEG_W-bit segments. Returns 0 for a
//                           degenerate segment width so the top-level
//                           elaboration checks can report it cleanly.
//
// The per-stage record type depends on WIDTH. It is therefore declared
// inside pipe_adder, next to the localparams that size it.
package pipe_adder_pkg;

  function automatic int num_seg(input int width, input int seg_w);
    return (seg_w > 0) ? (width / seg_w) : 0;
  endfunction

endpackage : pipe_adder_pkg

// File: rtl/adder_seg.sv
// adder_seg -- purely combinational SEG_W-bit ripple-carry segment.
//
// Built from full-adder bit slices:
//   s = a ^ b ^ c
//   cout = (a & b) | (c & (a ^ b))
//
// Ports:
//   a, b      in  SEG_W  segment operands
//   cin       in  1      carry into bit 0 of the segment
//   s         out SEG_W  segment sum
//   cout      out 1      carry out of the segment's top bit
//   c_msb_in  out 1      carry into the segment's top bit. The top-level
//                        design uses this signal for the signed-overflow
//                        flag on its last segment.
module adder_seg #(
  parameter int SEG_W = 2
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  // The ripple is written as a loop over a scalar carry. This keeps the
  // chain inside one process instead of a self-referencing carry vector.
  logic w_c;

  always_comb begin
    w_c      = cin;
    s        = '0;
    c_msb_in = cin;
    for (int i = 0; i < SEG_W; i++) begin
      c_msb_in = w_c;
      s[i]     = a[i] ^ b[i] ^ w_c;
      w_c      = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    cout = w_c;
  end

endmodule : adder_seg

// File: rtl/pipe_adder.sv
// pipe_adder -- WIDTH-bit unsigned adder with carry-in. The add is split
// into NUM_SEG = WIDTH/SEG_W pipeline stages, and each stage adds one
// SEG_W-bit segment.
//
// Stage register k holds the result after segments 0..k have been added:
//   valid, carry (out of segment k), sum_lo (low (k+1)*SEG_W bits valid),
//   a_hi/b_hi (operand bits not yet consumed; consumed bits are zeroed).
// Segment 0 is added combinationally from the inputs into register 0. An
// operand accepted at edge n is therefore presented on the outputs after
// edge n+NUM_SEG-1. The last stage register drives sum/carry_out/out_valid
// directly, so the outputs are registered.
//
// Flow control is per stage. Each stage moves when it is empty or when
// the stage downstream moves, so bubbles collapse and a full pipeline can
// accept and drain in the same cycle.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready = stage 0 can advance)
//   a, b, carry_in       operands
//   out_valid/out_ready  result handshake
//   sum, carry_out       (a + b + carry_in) mod 2^WIDTH and the carry out
//   overflow             only with `define PIPE_ADDER_OVF_EN: signed
//                        two's-complement overflow, registered with sum
//
// Optional feature macro: PIPE_ADDER_OVF_EN
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SEG_W   = 2,
  parameter int NUM_SEG = num_seg(WIDTH, SEG_W)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  // Parameter sanity checks, evaluated at elaboration time.
  if (WIDTH < 1 || SEG_W < 1) begin : g_bad_width
    $error("pipe_adder: WIDTH (%0d) and SEG_W (%0d) must be >= 1", WIDTH, SEG_W);
  end else if (WIDTH % SEG_W != 0) begin : g_bad_seg
    $error("pipe_adder: WIDTH (%0d) must be a multiple of SEG_W (%0d)", WIDTH, SEG_W);
  end else if (NUM_SEG != WIDTH / SEG_W) begin : g_bad_num
    $error("pipe_adder: NUM_SEG is derived and must equal WIDTH/SEG_W");
  end

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum_lo;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
  } stage_t;

  stage_t             w_stg [NUM_SEG];  // stage registers, gathered
  logic [NUM_SEG-1:0] w_vld;
  logic [NUM_SEG:0]   w_adv;            // w_adv[k]: stage k loads this edge

`ifdef PIPE_ADDER_OVF_EN
  logic w_ovf_d;   // overflow of the result entering the last stage
  logic w_ovf_ld;  // last stage loads a valid result this edge
  logic r_ovf;
`endif

  // Advance chain, evaluated from the output side back to the input.
  always_comb begin
    w_adv          = '0;
    w_adv[NUM_SEG] = out_ready;
    for (int k = NUM_SEG - 1; k >= 0; k--) begin
      w_adv[k] = ~w_vld[k] | w_adv[k+1];
    end
  end

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_stg
    stage_t           w_src;  // record feeding this stage
    stage_t           w_nxt;  // record after adding segment k
    stage_t           r_stg;
    logic [SEG_W-1:0] w_s;
    logic             w_co;
    logic             w_cm;

    if (k == 0) begin : g_head
      always_comb begin
        w_src       = '0;
        w_src.valid = in_valid;
        w_src.carry = carry_in;
        w_src.a_hi  = a;
        w_src.b_hi  = b;
      end
    end else begin : g_body
      assign w_src = w_stg[k-1];
    end

    adder_seg #(.SEG_W(SEG_W)) u_seg (
      .a        (w_src.a_hi[k*SEG_W +: SEG_W]),
      .b        (w_src.b_hi[k*SEG_W +: SEG_W]),
      .cin      (w_src.carry),
      .s        (w_s),
      .cout     (w_co),
      .c_msb_in (w_cm)
    );

    // Zero the consumed operand bits. The registers then carry only the
    // bits that later stages still need.
    always_comb begin
      w_nxt                             = w_src;
      w_nxt.carry                       = w_co;
      w_nxt.sum_lo[k*SEG_W +: SEG_W]    = w_s;
      w_nxt.a_hi[k*SEG_W +: SEG_W]      = '0;
      w_nxt.b_hi[k*SEG_W +: SEG_W]      = '0;
    end

    // Data loads only with a valid token. A bubble moving through the
    // stage clears only its valid bit, so the last result stays visible.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_stg <= '0;
      end else if (w_adv[k]) begin
        if (w_src.valid) r_stg <= w_nxt;
        else             r_stg.valid <= 1'b0;
      end
    end

    assign w_stg[k] = r_stg;
    assign w_vld[k] = r_stg.valid;

`ifdef PIPE_ADDER_OVF_EN
    if (k == NUM_SEG - 1) begin : g_ovf
      // The MSB lies in the last segment: overflow = carry into MSB ^ carry out.
      assign w_ovf_d  = w_cm ^ w_co;
      assign w_ovf_ld = w_adv[k] & w_src.valid;
    end
`endif
  end

  assign in_ready  = w_adv[0];
  assign out_valid = w_stg[NUM_SEG-1].valid;
  assign sum       = w_stg[NUM_SEG-1].sum_lo;
  assign carry_out = w_stg[NUM_SEG-1].carry;

`ifdef PIPE_ADDER_OVF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_ovf <= 1'b0;
    else if (w_ovf_ld) r_ovf <= w_ovf_d;
  end

  assign overflow = r_ovf;
`endif

endmodule : pipe_adder
